mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage data-memory access unit; consumes the registered EX/MEM bundle (ME_*).
//   Performs byte/half/word store alignment and load extraction with sign/zero extension.
//   Runs a req/ready handshake to data memory and stalls the pipeline while an access is outstanding.
//   Registers the result into the MEM/WB bundle (WB_*).
// PARAMETERS
//   TIMEOUT  16           max WAIT cycles without dm_ready before bus error (>=1)
//   PC_RST   32'h00003000 reset value of WB_PC
// PORTS
//   clock          in   1   clock, rising edge
//   reset          in   1   asynchronous, active-low
//   ME_Alu_Result  in   32  effective address (mem op) or ALU result
//   ME_NUM_B       in   32  store data (rt)
//   ME_PC          in   32  PC of instruction
//   ME_WriteReg    in   5   destination register
//   ME_load_option in   3   000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu (others = lw)
//   ME_save_option in   2   00 sw, 01 sb, 10 sh, 11 = sw
//   ME_WriteEnable in   1   reg write enable
//   ME_MemWrite    in   1   store
//   ME_MemtoReg    in   1   load
//   dm_req         out  1   memory request (combinational)
//   dm_we          out  1   write strobe, valid with dm_req
//   dm_addr        out  32  {ME_Alu_Result[31:2],2'b00}
//   dm_be          out  4   byte enables
//   dm_wdata       out  32  lane-replicated store data
//   dm_rdata       in   32  read data, valid when dm_ready
//   dm_ready       in   1   access complete this cycle
//   mem_stall      out  1   hold PC/IF/ID/EX/MEM regs (combinational)
//   WB_WriteEnable out  1   registered
//   WB_WriteReg    out  5   registered
//   WB_Data        out  32  registered write-back data
//   WB_PC          out  32  registered
//   addr_err       out  1   one-cycle pulse: misaligned access
//   bus_err        out  1   one-cycle pulse: timeout
// BEHAVIOUR
//   - Reset (async, reset==0): state IDLE, wait counter 0, WB_* 0, WB_PC=PC_RST, addr_err=bus_err=0.
//   - acc = ME_MemWrite|ME_MemtoReg; if both are set, the access is a store.
//   - Misaligned: half op with a[0]=1, or word op with a[1:0]!=0. No dm_req; next edge WB_WriteEnable=0,
//     WB_PC=ME_PC, addr_err=1 for one cycle; no stall.
//   - Stores: sb dm_be=4'b0001<<a[1:0], wdata={4{B[7:0]}}; sh dm_be=a[1]?1100:0011,
//     wdata={2{B[15:0]}}; sw dm_be=1111, wdata=B.
//   - Loads: dm_be=1111, dm_we=0; byte/half selected by a[1:0]/a[1]; lb/lh sign-extend, lbu/lhu zero-extend.
//   - FSM IDLE/WAIT. dm_req=(IDLE&acc&aligned)|WAIT. mem_stall=dm_req&!dm_ready.
//   - IDLE: aligned acc & dm_ready -> zero-wait, complete this edge, stay IDLE.
//     aligned acc & !dm_ready -> WAIT, cnt=1.
//   - WAIT: dm_ready -> complete, IDLE, cnt=0.
//     !dm_ready & cnt==TIMEOUT -> IDLE, bus_err pulse, WB bubble, stall drops that cycle.
//     Otherwise cnt++.
//   - ME_* are held stable by the stall while in WAIT; dm_* are driven from them each cycle.
//   - Complete/non-mem edge: WB_WriteEnable=ME_WriteEnable, WB_WriteReg=ME_WriteReg, WB_PC=ME_PC,
//     WB_Data=load?extracted:ME_Alu_Result. While stalled (not yet complete), WB_WriteEnable=0 (bubble).
//   - Latency: non-mem and zero-wait ops 1 cycle; an N-wait access gives N stall cycles plus 1.
//   - Reset asserted mid-WAIT aborts the access: dm_req drops immediately, no WB write.
// TESTING
//   1 Non-mem: Alu=32'h1234, WE=1, WReg=5 -> next edge WB_Data=32'h1234, WB_WriteEnable=1, no stall.
//   2 lb, addr 0x..03, dm_rdata=32'h80FF_FF7F, ready 0-wait -> WB_Data=32'hFFFFFF80;
//     lbu gives 32'h00000080.
//   3 sh addr 0x..02, B=32'hAAAA_BEEF -> dm_be=4'b1100, dm_wdata=32'hBEEFBEEF, dm_we=1.
//   4 lw with dm_ready after 3 cycles -> mem_stall high exactly 3 cycles, WB_* written once, 1 cycle later.
//   5 dm_ready never, TIMEOUT=16 -> stall for 16 cycles, bus_err pulse, WB_WriteEnable=0, FSM IDLE.
//   6 lw addr 0x..02 -> addr_err pulse, dm_req never high; reset pulse mid-WAIT -> WB_PC=0x3000, all outputs 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: aligns stores, extracts/extends loads, runs the
// req/ready handshake with a timeout, and registers the MEM/WB bundle.
module mem_access_unit #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] PC_RST  = 32'h0000_3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ME_Alu_Result,
  input  logic [31:0] ME_NUM_B,
  input  logic [31:0] ME_PC,
  input  logic [4:0]  ME_WriteReg,
  input  logic [2:0]  ME_load_option,
  input  logic [1:0]  ME_save_option,
  input  logic        ME_WriteEnable,
  input  logic        ME_MemWrite,
  input  logic        ME_MemtoReg,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        mem_stall,
  output logic        WB_WriteEnable,
  output logic [4:0]  WB_WriteReg,
  output logic [31:0] WB_Data,
  output logic [31:0] WB_PC,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic        is_store, is_load, acc, is_byte, is_half, misaligned;
  logic        in_wait, timeout_hit, complete, wb_take;
  logic [1:0]  a_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign a_lo     = ME_Alu_Result[1:0];
  assign is_store = ME_MemWrite;
  assign is_load  = ME_MemtoReg & ~ME_MemWrite;
  assign acc      = ME_MemWrite | ME_MemtoReg;

  // Access size comes from the store option for stores, else from the load option.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (is_store) begin
      is_byte = (ME_save_option == 2'b01);
      is_half = (ME_save_option == 2'b10);
    end else begin
      case (ME_load_option)
        3'b001, 3'b010: is_byte = 1'b1;
        3'b011, 3'b100: is_half = 1'b1;
        default: ;
      endcase
    end
  end

  assign misaligned  = acc & ((is_half & a_lo[0]) | (~is_byte & ~is_half & (a_lo != 2'b00)));
  assign in_wait     = (state_reg == WAIT);
  assign timeout_hit = in_wait & ~dm_ready & (cnt_reg == TMAX);

  // Reset gating makes an in-flight request vanish the moment reset asserts.
  assign dm_req    = reset & ((~in_wait & acc & ~misaligned) | in_wait);
  assign dm_we     = dm_req & is_store;
  assign dm_addr   = {ME_Alu_Result[31:2], 2'b00};
  assign mem_stall = dm_req & ~dm_ready & ~timeout_hit;
  assign complete  = dm_req & dm_ready;
  assign wb_take   = (~in_wait & ~acc) | complete;

  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = ME_NUM_B;
    if (is_byte) begin
      dm_wdata = {4{ME_NUM_B[7:0]}};
    end else if (is_half) begin
      dm_wdata = {2{ME_NUM_B[15:0]}};
    end
    if (is_store && is_byte) begin
      dm_be = 4'b0001 << a_lo;
    end else if (is_store && is_half) begin
      dm_be = a_lo[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    case (a_lo)
      2'd0:    byte_sel = dm_rdata[7:0];
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    half_sel = a_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (ME_load_option)
      3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_data = {24'd0, byte_sel};
      3'b011:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {16'd0, half_sel};
      default: load_data = dm_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (dm_req && !dm_ready) begin
          state_next = WAIT;
          cnt_next   = CW'(1);
        end
      end
      WAIT: begin
        if (dm_ready || timeout_hit) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Anything that is not a completion leaves a bubble in WB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      WB_WriteEnable <= 1'b0;
      WB_WriteReg    <= '0;
      WB_Data        <= '0;
      WB_PC          <= PC_RST;
      addr_err       <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      if (wb_take) begin
        WB_WriteEnable <= ME_WriteEnable;
        WB_WriteReg    <= ME_WriteReg;
        WB_PC          <= ME_PC;
        WB_Data        <= is_load ? load_data : ME_Alu_Result;
      end else if (!in_wait && misaligned) begin
        WB_WriteEnable <= 1'b0;
        WB_PC          <= ME_PC;
        addr_err       <= 1'b1;
      end else if (timeout_hit) begin
        WB_WriteEnable <= 1'b0;
        bus_err        <= 1'b1;
      end else begin
        WB_WriteEnable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: alignment, extension, wait states, timeout,
// misaligned access and reset abort, with hand-computed expectations.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic [31:0] ME_Alu_Result, ME_NUM_B, ME_PC;
  logic [4:0]  ME_WriteReg;
  logic [2:0]  ME_load_option;
  logic [1:0]  ME_save_option;
  logic        ME_WriteEnable, ME_MemWrite, ME_MemtoReg;
  logic        dm_req, dm_we, dm_ready, mem_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        WB_WriteEnable;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_Data, WB_PC;
  logic        addr_err, bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT(16), .PC_RST(32'h0000_3000)) dut (
    .clock(clock), .reset(reset),
    .ME_Alu_Result(ME_Alu_Result), .ME_NUM_B(ME_NUM_B), .ME_PC(ME_PC),
    .ME_WriteReg(ME_WriteReg), .ME_load_option(ME_load_option),
    .ME_save_option(ME_save_option), .ME_WriteEnable(ME_WriteEnable),
    .ME_MemWrite(ME_MemWrite), .ME_MemtoReg(ME_MemtoReg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_stall(mem_stall), .WB_WriteEnable(WB_WriteEnable),
    .WB_WriteReg(WB_WriteReg), .WB_Data(WB_Data), .WB_PC(WB_PC),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] wreg,
                        input logic we, input logic mw, input logic mr,
                        input logic [2:0] lopt, input logic [1:0] sopt);
    ME_Alu_Result  = alu;
    ME_PC          = pc;
    ME_WriteReg    = wreg;
    ME_WriteEnable = we;
    ME_MemWrite    = mw;
    ME_MemtoReg    = mr;
    ME_load_option = lopt;
    ME_save_option = sopt;
  endtask

  task automatic load_case(input string tag, input logic [2:0] lopt, input logic [31:0] addr,
                           input logic [31:0] exp);
    set_op(addr, 32'h0000_0200, 5'd7, 1'b1, 1'b0, 1'b1, lopt, 2'b00);
    dm_rdata = 32'h80FF_FF7F;
    dm_ready = 1'b1;
    #1;
    chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
    next_cycle();
    chk({tag, "_data"}, WB_Data, exp);
    $display("txn %s addr=%h data=%h", tag, addr, WB_Data);
  endtask

  int stalls, writes, write_cyc, pulses, pulse_cyc, req_seen;

  initial begin
    reset = 1'b0;
    ME_NUM_B = '0;
    dm_rdata = '0;
    dm_ready = 1'b0;
    set_op(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wb_pc", WB_PC, 32'h0000_3000);
    chk("rst_wb_we", 32'(WB_WriteEnable), 32'd0);
    chk("rst_wb_data", WB_Data, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    next_cycle();

    // Non-memory instruction
    set_op(32'h0000_1234, 32'h0000_0100, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
    #1;
    chk("nonmem_req", 32'(dm_req), 32'd0);
    chk("nonmem_stall", 32'(mem_stall), 32'd0);
    next_cycle();
    chk("nonmem_data", WB_Data, 32'h0000_1234);
    chk("nonmem_we", 32'(WB_WriteEnable), 32'd1);
    chk("nonmem_wreg", 32'(WB_WriteReg), 32'd5);
    chk("nonmem_pc", WB_PC, 32'h0000_0100);
    $display("txn nonmem data=%h", WB_Data);

    // Zero-wait loads
    set_op(32'h0000_0103, 32'h0000_0200, 5'd7, 1'b1, 1'b0, 1'b1, 3'b001, 2'b00);
    dm_rdata = 32'h80FF_FF7F;
    dm_ready = 1'b1;
    #1;
    chk("lb_req", 32'(dm_req), 32'd1);
    chk("lb_we", 32'(dm_we), 32'd0);
    chk("lb_be", 32'(dm_be), 32'hF);
    chk("lb_addr", dm_addr, 32'h0000_0100);
    load_case("lb", 3'b001, 32'h0000_0103, 32'hFFFF_FF80);
    load_case("lbu", 3'b010, 32'h0000_0103, 32'h0000_0080);
    load_case("lb0", 3'b001, 32'h0000_0100, 32'h0000_007F);
    load_case("lh2", 3'b011, 32'h0000_0102, 32'hFFFF_80FF);
    load_case("lhu0", 3'b100, 32'h0000_0100, 32'h0000_FF7F);

    // Stores
    set_op(32'h0000_0202, 32'h0000_0300, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b10);
    ME_NUM_B = 32'hAAAA_BEEF;
    dm_ready = 1'b1;
    #1;
    chk("sh_be", 32'(dm_be), 32'hC);
    chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    chk("sh_we", 32'(dm_we), 32'd1);
    chk("sh_req", 32'(dm_req), 32'd1);
    next_cycle();
    chk("sh_wb_we", 32'(WB_WriteEnable), 32'd0);
    $display("txn sh be=c wdata=beefbeef");
    set_op(32'h0000_0201, 32'h0000_0304, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b01);
    #1;
    chk("sb_be", 32'(dm_be), 32'h2);
    chk("sb_wdata", dm_wdata, 32'hEFEF_EFEF);
    next_cycle();
    set_op(32'h0000_0204, 32'h0000_0308, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00);
    #1;
    chk("sw_be", 32'(dm_be), 32'hF);
    chk("sw_wdata", dm_wdata, 32'hAAAA_BEEF);
    next_cycle();
    $display("txn sb/sw");

    // lw with three wait cycles
    set_op(32'h0000_0300, 32'h0000_0400, 5'd9, 1'b1, 1'b0, 1'b1, 3'b000, 2'b00);
    dm_rdata = 32'hDEAD_BEEF;
    dm_ready = 1'b0;
    stalls = 0; writes = 0; write_cyc = -1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dm_ready = 1'b1;
      #1;
      if (mem_stall) stalls++;
      next_cycle();
      if (WB_WriteEnable) begin
        writes++;
        write_cyc = c;
      end
    end
    chk("lw3_stalls", 32'(stalls), 32'd3);
    chk("lw3_writes", 32'(writes), 32'd1);
    chk("lw3_wcycle", 32'(write_cyc), 32'd3);
    chk("lw3_data", WB_Data, 32'hDEAD_BEEF);
    chk("lw3_wreg", 32'(WB_WriteReg), 32'd9);
    set_op(32'd0, 32'h0000_0404, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    next_cycle();
    chk("lw3_once", 32'(WB_WriteEnable), 32'd0);
    $display("txn lw wait=3 stalls=%0d", stalls);

    // Timeout: dm_ready never comes
    set_op(32'h0000_0500, 32'h0000_0600, 5'd3, 1'b1, 1'b0, 1'b1, 3'b000, 2'b00);
    dm_ready = 1'b0;
    stalls = 0; writes = 0; pulses = 0; pulse_cyc = -1;
    for (int c = 0; c < 17; c++) begin
      #1;
      if (mem_stall) stalls++;
      next_cycle();
      if (WB_WriteEnable) writes++;
      if (bus_err) begin
        pulses++;
        pulse_cyc = c;
      end
    end
    chk("to_stalls", 32'(stalls), 32'd16);
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_pcycle", 32'(pulse_cyc), 32'd16);
    chk("to_writes", 32'(writes), 32'd0);
    set_op(32'd0, 32'h0000_0604, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    #1;
    chk("to_idle_req", 32'(dm_req), 32'd0);
    next_cycle();
    chk("to_pulse_end", 32'(bus_err), 32'd0);
    $display("txn timeout stalls=%0d", stalls);

    // Misaligned lw
    set_op(32'h0000_0702, 32'h0000_0800, 5'd4, 1'b1, 1'b0, 1'b1, 3'b000, 2'b00);
    dm_ready = 1'b1;
    #1;
    req_seen = int'(dm_req);
    chk("mis_req", 32'(req_seen), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    next_cycle();
    chk("mis_addr_err", 32'(addr_err), 32'd1);
    chk("mis_wb_we", 32'(WB_WriteEnable), 32'd0);
    chk("mis_wb_pc", WB_PC, 32'h0000_0800);
    set_op(32'd0, 32'h0000_0804, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    next_cycle();
    chk("mis_pulse_end", 32'(addr_err), 32'd0);
    $display("txn misaligned lw");

    // Reset asserted while waiting
    set_op(32'h0000_0900, 32'h0000_0A00, 5'd6, 1'b1, 1'b0, 1'b1, 3'b000, 2'b00);
    dm_ready = 1'b0;
    next_cycle();
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("rw_req", 32'(dm_req), 32'd0);
    chk("rw_stall", 32'(mem_stall), 32'd0);
    chk("rw_wb_pc", WB_PC, 32'h0000_3000);
    chk("rw_wb_we", 32'(WB_WriteEnable), 32'd0);
    chk("rw_wb_data", WB_Data, 32'd0);
    chk("rw_errs", 32'({addr_err, bus_err}), 32'd0);
    $display("txn reset mid-wait");
    @(negedge clock);
    reset = 1'b1;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
